cu_vertex_read_line_merge: RTL and testbench

//  Downstream of the vertex cache stage. Accepts its response and two half-cacheline data streams.

---
 rtl/cu_vertex_read_line_merge.sv | 199 +++++++++++++++++++
 tb/tb_cu_vertex_read_line_merge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_vertex_read_line_merge.sv
// Vertex read line merge: pairs the cache response with two half-line streams through per-stream FIFOs.
// Optional VERTEX_MERGE_STATS_EN adds wrapping transfer/stall counters; otherwise those ports are 0.

module cu_vertex_read_line_merge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     push_in,
  input  logic [W-1:0]             din_in,
  input  logic                     pop_in,
  output logic [W-1:0]             dout_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     ovf_out
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         full, pop_ok, push_ok;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is then accepted.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_out = (wr_ptr_q == rd_ptr_q);
    pop_ok    = pop_in && !empty_out;
    push_ok   = push_in && (!full || pop_ok);
    ovf_out   = push_in && full && !pop_ok;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    count_out = wr_ptr_q - rd_ptr_q;
    dout_out  = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din_in;
  end
endmodule

module cu_vertex_read_line_merge #(
  parameter int HALF_W     = 512,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clock,
  input  logic                  rstn_in,
  input  logic                  enabled_in,
  input  logic                  resp_valid_in,
  input  logic [TAG_W-1:0]      resp_tag_in,
  input  logic                  d0_valid_in,
  input  logic [TAG_W-1:0]      d0_tag_in,
  input  logic [HALF_W-1:0]     d0_data_in,
  input  logic                  d1_valid_in,
  input  logic [TAG_W-1:0]      d1_tag_in,
  input  logic [HALF_W-1:0]     d1_data_in,
  input  logic                  line_ready_in,
  output logic                  line_valid_out,
  output logic [TAG_W-1:0]      line_tag_out,
  output logic [2*HALF_W-1:0]   line_data_out,
  output logic                  almost_full_out,
  output logic                  tag_err_out,
  output logic                  ovf_err_out,
  output logic [31:0]           merged_cnt_out,
  output logic [31:0]           stall_cnt_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(FIFO_DEPTH - AF_MARGIN);

  // Assertion follows rstn_in immediately; release waits for one clock edge.
  logic rst_int_q;
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rst_int_q <= 1'b0;
    else          rst_int_q <= 1'b1;
  end

  logic                in_resp_v_q, in_resp_v_d, in_d0_v_q, in_d0_v_d, in_d1_v_q, in_d1_v_d;
  logic [TAG_W-1:0]    in_resp_tag_q, in_resp_tag_d;
  logic [TAG_W+HALF_W-1:0] in_d0_q, in_d0_d, in_d1_q, in_d1_d;

  logic                line_valid_q, line_valid_d, tag_err_q, tag_err_d, ovf_err_q, ovf_err_d;
  logic [TAG_W-1:0]    line_tag_q, line_tag_d;
  logic [2*HALF_W-1:0] line_data_q, line_data_d;

  logic                    pop;
  logic                    r_empty, d0_empty, d1_empty, r_ovf, d0_ovf, d1_ovf;
  logic [AW:0]             r_cnt, d0_cnt, d1_cnt;
  logic [TAG_W-1:0]        r_tag;
  logic [TAG_W+HALF_W-1:0] d0_ent, d1_ent;

  cu_vertex_read_line_merge_fifo #(.W(TAG_W), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
    .clock(clock), .rst_n(rst_int_q), .push_in(in_resp_v_q), .din_in(in_resp_tag_q),
    .pop_in(pop), .dout_out(r_tag), .empty_out(r_empty), .count_out(r_cnt), .ovf_out(r_ovf));
  cu_vertex_read_line_merge_fifo #(.W(TAG_W+HALF_W), .DEPTH(FIFO_DEPTH)) u_d0_fifo (
    .clock(clock), .rst_n(rst_int_q), .push_in(in_d0_v_q), .din_in(in_d0_q),
    .pop_in(pop), .dout_out(d0_ent), .empty_out(d0_empty), .count_out(d0_cnt), .ovf_out(d0_ovf));
  cu_vertex_read_line_merge_fifo #(.W(TAG_W+HALF_W), .DEPTH(FIFO_DEPTH)) u_d1_fifo (
    .clock(clock), .rst_n(rst_int_q), .push_in(in_d1_v_q), .din_in(in_d1_q),
    .pop_in(pop), .dout_out(d1_ent), .empty_out(d1_empty), .count_out(d1_cnt), .ovf_out(d1_ovf));

  always_comb begin
    in_resp_v_d   = resp_valid_in;
    in_resp_tag_d = resp_tag_in;
    in_d0_v_d     = d0_valid_in;
    in_d0_d       = {d0_tag_in, d0_data_in};
    in_d1_v_d     = d1_valid_in;
    in_d1_d       = {d1_tag_in, d1_data_in};

    pop = enabled_in && !r_empty && !d0_empty && !d1_empty && (!line_valid_q || line_ready_in);

    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    if (pop) begin
      line_valid_d = 1'b1;
      line_tag_d   = r_tag;
      line_data_d  = {d1_ent[HALF_W-1:0], d0_ent[HALF_W-1:0]};
    end else if (line_valid_q && line_ready_in) begin
      line_valid_d = 1'b0;
    end

    // Mismatched lines are still emitted; only the sticky flag records them.
    tag_err_d = tag_err_q || (pop && ((d0_ent[TAG_W+HALF_W-1:HALF_W] != r_tag) ||
                                      (d1_ent[TAG_W+HALF_W-1:HALF_W] != r_tag)));
    ovf_err_d = ovf_err_q || r_ovf || d0_ovf || d1_ovf;
  end

  always_ff @(posedge clock or negedge rst_int_q) begin
    if (!rst_int_q) begin
      in_resp_v_q   <= 1'b0;
      in_resp_tag_q <= '0;
      in_d0_v_q     <= 1'b0;
      in_d0_q       <= '0;
      in_d1_v_q     <= 1'b0;
      in_d1_q       <= '0;
      line_valid_q  <= 1'b0;
      line_tag_q    <= '0;
      line_data_q   <= '0;
      tag_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      in_resp_v_q   <= in_resp_v_d;
      in_resp_tag_q <= in_resp_tag_d;
      in_d0_v_q     <= in_d0_v_d;
      in_d0_q       <= in_d0_d;
      in_d1_v_q     <= in_d1_v_d;
      in_d1_q       <= in_d1_d;
      line_valid_q  <= line_valid_d;
      line_tag_q    <= line_tag_d;
      line_data_q   <= line_data_d;
      tag_err_q     <= tag_err_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign line_valid_out  = line_valid_q;
  assign line_tag_out    = line_tag_q;
  assign line_data_out   = line_data_q;
  assign tag_err_out     = tag_err_q;
  assign ovf_err_out     = ovf_err_q;
  assign almost_full_out = (r_cnt >= AF_LVL) || (d0_cnt >= AF_LVL) || (d1_cnt >= AF_LVL);

`ifdef VERTEX_MERGE_STATS_EN
  logic [31:0] merged_cnt_q, merged_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    merged_cnt_d = merged_cnt_q + ((line_valid_q && line_ready_in) ? 32'd1 : 32'd0);
    stall_cnt_d  = stall_cnt_q + ((line_valid_q && !line_ready_in) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock or negedge rst_int_q) begin
    if (!rst_int_q) begin
      merged_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      merged_cnt_q <= merged_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign merged_cnt_out = merged_cnt_q;
  assign stall_cnt_out  = stall_cnt_q;
`else
  assign merged_cnt_out = 32'd0;
  assign stall_cnt_out  = 32'd0;
`endif
endmodule

// File: tb/tb_cu_vertex_read_line_merge.sv
// Scoreboard bench for cu_vertex_read_line_merge: random stream traffic plus directed latency,
// overflow, tag-error, reset and statistics scenarios.

module tb_cu_vertex_read_line_merge;
  localparam int NL = 80;

  typedef struct {
    logic [7:0]    tag;
    logic [1023:0] data;
  } line_t;

  logic          clock = 1'b0;
  logic          rstn_in, enabled_in, line_ready_in;
  logic          resp_valid_in, d0_valid_in, d1_valid_in;
  logic [7:0]    resp_tag_in, d0_tag_in, d1_tag_in;
  logic [511:0]  d0_data_in, d1_data_in;
  logic          line_valid_out, almost_full_out, tag_err_out, ovf_err_out;
  logic [7:0]    line_tag_out;
  logic [1023:0] line_data_out;
  logic [31:0]   merged_cnt_out, stall_cnt_out;

  cu_vertex_read_line_merge dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in),
    .resp_valid_in(resp_valid_in), .resp_tag_in(resp_tag_in),
    .d0_valid_in(d0_valid_in), .d0_tag_in(d0_tag_in), .d0_data_in(d0_data_in),
    .d1_valid_in(d1_valid_in), .d1_tag_in(d1_tag_in), .d1_data_in(d1_data_in),
    .line_ready_in(line_ready_in), .line_valid_out(line_valid_out),
    .line_tag_out(line_tag_out), .line_data_out(line_data_out),
    .almost_full_out(almost_full_out), .tag_err_out(tag_err_out), .ovf_err_out(ovf_err_out),
    .merged_cnt_out(merged_cnt_out), .stall_cnt_out(stall_cnt_out));

  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_pass = 0;
  int    rx_cnt = 0;
  int    xfer_b = 0;
  int    stall_b = 0;
  line_t exp_q[$];

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act[127:0], exp[127:0]);
  endtask

  function automatic logic [511:0] rand_half();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [7:0] rt,
                       input logic v0, input logic [7:0] t0, input logic [511:0] a,
                       input logic v1, input logic [7:0] t1, input logic [511:0] b);
    resp_valid_in = rv; resp_tag_in = rt;
    d0_valid_in = v0; d0_tag_in = t0; d0_data_in = a;
    d1_valid_in = v1; d1_tag_in = t1; d1_data_in = b;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
  endtask

  task automatic triple(input logic [7:0] t, input logic push_exp);
    logic [511:0] a, b;
    a = rand_half();
    b = rand_half();
    drive(1'b1, t, 1'b1, t, a, 1'b1, t, b);
    if (push_exp) exp_q.push_back('{t, {b, a}});
  endtask

  task automatic wait_rx(input int target, input string nm);
    int g = 0;
    while (rx_cnt < target && g < 500) begin step(); g++; end
    chk(nm, rx_cnt, target);
  endtask

  // Monitor: scoreboard pop on each transfer, hold-stability while stalled, reference stats.
  logic          hold_pend = 1'b0;
  logic [7:0]    hold_tag;
  logic [1023:0] hold_data;
  always @(negedge clock) begin
    if (!rstn_in) begin
      hold_pend = 1'b0;
      xfer_b = 0;
      stall_b = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", line_valid_out, 1'b1);
        chk("hold_tag", line_tag_out, hold_tag);
        chk("hold_data", line_data_out, hold_data);
      end
      hold_pend = line_valid_out && !line_ready_in;
      hold_tag  = line_tag_out;
      hold_data = line_data_out;
      if (line_valid_out && !line_ready_in) stall_b++;
      if (line_valid_out && line_ready_in) begin
        line_t e;
        xfer_b++;
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_line actual_tag=%0h required=no_line", line_tag_out);
        end else begin
          e = exp_q.pop_front();
          chk("line_tag", line_tag_out, e.tag);
          chk("line_data", line_data_out, e.data);
        end
      end
    end
  end

  task automatic chk_stats(input string nm, input int m, input int s);
`ifdef VERTEX_MERGE_STATS_EN
    chk({nm, "_merged"}, merged_cnt_out, m);
    chk({nm, "_stall"}, stall_cnt_out, s);
`else
    chk({nm, "_merged"}, merged_cnt_out, 0 * m);
    chk({nm, "_stall"}, stall_cnt_out, 0 * s);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   r_tag [NL];
    logic [511:0] r_d0 [NL];
    logic [511:0] r_d1 [NL];
    logic [511:0] a, b;
    int           iss [3];
    int           exp_n, base;
    logic [2:0]   v;

    rstn_in = 1'b0; enabled_in = 1'b1; line_ready_in = 1'b1;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", line_valid_out, 0);
    chk("rst_tag", line_tag_out, 0);
    chk("rst_data", line_data_out, 0);
    chk("rst_af", almost_full_out, 0);
    chk("rst_tagerr", tag_err_out, 0);
    chk("rst_ovf", ovf_err_out, 0);
    chk_stats("rst", 0, 0);
    rstn_in = 1'b1;
    repeat (2) step();

    // Random independent streams; model pairs the k-th beat of each stream.
    for (int j = 0; j < NL; j++) begin
      r_tag[j] = 8'($urandom);
      r_d0[j] = rand_half();
      r_d1[j] = rand_half();
    end
    iss = '{0, 0, 0};
    exp_n = 0;
    for (int c = 0; c < 3000 && rx_cnt < NL; c++) begin
      step();
      line_ready_in = ($urandom_range(3) != 0);
      enabled_in = ($urandom_range(7) != 0);
      for (int s = 0; s < 3; s++)
        v[s] = (iss[s] < NL) && (iss[s] - rx_cnt < 10) && ($urandom_range(1) == 1);
      drive(v[0], v[0] ? r_tag[iss[0]] : 8'h00,
            v[1], v[1] ? r_tag[iss[1]] : 8'h00, v[1] ? r_d0[iss[1]] : '0,
            v[2], v[2] ? r_tag[iss[2]] : 8'h00, v[2] ? r_d1[iss[2]] : '0);
      for (int s = 0; s < 3; s++) if (v[s]) iss[s]++;
      while (exp_n < iss[0] && exp_n < iss[1] && exp_n < iss[2]) begin
        exp_q.push_back('{r_tag[exp_n], {r_d1[exp_n], r_d0[exp_n]}});
        exp_n++;
      end
    end
    step();
    idle(); enabled_in = 1'b1; line_ready_in = 1'b1;
    wait_rx(NL, "rand_lines");
    repeat (3) step();
    chk("rand_tagerr", tag_err_out, 0);
    chk("rand_ovf", ovf_err_out, 0);
    chk_stats("rand", xfer_b, stall_b);

    // T1: all three beats together -> valid two edges after the sampling edge, for one cycle.
    a = rand_half(); b = rand_half();
    step();
    drive(1'b1, 8'h05, 1'b1, 8'h05, a, 1'b1, 8'h05, b);
    exp_q.push_back('{8'h05, {b, a}});
    @(negedge clock);
    chk("t1_valid_s0", line_valid_out, 0);
    for (int s = 1; s <= 4; s++) begin
      step(); idle();
      @(negedge clock);
      chk($sformatf("t1_valid_s%0d", s), line_valid_out, (s == 3));
    end

    // T2: staggered arrival; output only after the last (response) beat.
    a = rand_half(); b = rand_half();
    for (int s = 0; s <= 10; s++) begin
      step();
      drive(s == 6, 8'h11, s == 3, 8'h11, a, s == 0, 8'h11, b);
      if (s == 6) exp_q.push_back('{8'h11, {b, a}});
      @(negedge clock);
      chk($sformatf("t2_valid_s%0d", s), line_valid_out, (s == 9));
    end

    // T4: d1 tag mismatch -> line still emitted with response tag, sticky error.
    chk("t4_tagerr_before", tag_err_out, 0);
    a = rand_half(); b = rand_half();
    step();
    drive(1'b1, 8'h02, 1'b1, 8'h02, a, 1'b1, 8'h03, b);
    exp_q.push_back('{8'h02, {b, a}});
    step(); idle();
    repeat (5) step();
    chk("t4_tagerr", tag_err_out, 1);
    repeat (5) step();
    chk("t4_tagerr_sticky", tag_err_out, 1);

    // T3: pops frozen, 20 triples; 16 fit, the rest drop and flag overflow.
    enabled_in = 1'b0;
    base = rx_cnt;
    for (int i = 0; i < 20; i++) begin
      step(); triple(8'(8'h40 + i), i < 16);
      step(); idle();
      step();
      @(negedge clock);
      chk($sformatf("t3_af_%0d", i), almost_full_out, ((i < 16 ? i + 1 : 16) >= 14));
      chk($sformatf("t3_ovf_%0d", i), ovf_err_out, (i >= 16));
    end
    step();
    enabled_in = 1'b1;
    wait_rx(base + 16, "t3_lines");
    repeat (5) step();
    chk("t3_line_total", rx_cnt - base, 16);
    chk("t3_af_drained", almost_full_out, 0);
    chk("t3_ovf_sticky", ovf_err_out, 1);
    chk_stats("pre_t5", xfer_b, stall_b);

    // T5: reset with buffered lines and a presented line -> immediate clear, nothing afterwards.
    line_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); triple(8'(8'h70 + i), 1'b1); end
    step(); idle();
    repeat (3) step();
    @(negedge clock);
    chk("t5_valid_pre", line_valid_out, 1);
    #2;
    rstn_in = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_valid", line_valid_out, 0);
    chk("t5_tag", line_tag_out, 0);
    chk("t5_data", line_data_out, 0);
    chk("t5_af", almost_full_out, 0);
    chk("t5_tagerr", tag_err_out, 0);
    chk("t5_ovf", ovf_err_out, 0);
    chk_stats("t5", 0, 0);
    repeat (3) step();
    rstn_in = 1'b1;
    line_ready_in = 1'b1;
    base = rx_cnt;
    repeat (12) step();
    chk("t5_no_lines", rx_cnt - base, 0);
    chk("t5_valid_after", line_valid_out, 0);

    // T6: four lines, downstream stalls for three cycles.
    line_ready_in = 1'b0;
    base = rx_cnt;
    for (int i = 0; i < 4; i++) begin step(); triple(8'(8'h90 + i), 1'b1); end
    step(); idle();
    for (int g = 0; g < 50 && stall_b < 3; g++) step();
    line_ready_in = 1'b1;
    wait_rx(base + 4, "t6_lines");
    repeat (3) step();
    chk_stats("t6", 4, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
